// File: rtl/aes_ctrl_pkg.sv
// Codes shared by the AES encrypt and decrypt control FSMs.
// Includes state codes, state-matrix mux selects and the round count.
package aes_ctrl_pkg;

    localparam int NUM_ROUNDS_DEFAULT = 10;

    typedef enum logic [3:0] {
        IDLE              = 4'd0,
        CTEXT_WRITE       = 4'd1,
        KEY_WRITE         = 4'd2,
        COMPUTE_ROUNDKEYS = 4'd3,
        INV_SHIFTROWS     = 4'd4,
        INV_SUBBYTES      = 4'd5,
        INV_MIXCOLUMNS    = 4'd6,
        ADDROUNDKEY       = 4'd7,
        DECRYPTION_DONE   = 4'd8,
        PTEXT_READ        = 4'd9,
        INIT_ADDROUNDKEY  = 4'd10
    } state_e;

    localparam logic [3:0] SEL_EXTERNAL       = 4'd0;
    localparam logic [3:0] SEL_ADDROUNDKEY    = 4'd4;
    localparam logic [3:0] SEL_INV_SUBBYTES   = 4'd5;
    localparam logic [3:0] SEL_INV_SHIFTROWS  = 4'd6;
    localparam logic [3:0] SEL_INV_MIXCOLUMNS = 4'd7;

    // States that walk the matrix one row/column per cycle for four cycles
    function automatic logic is_beat_state(input state_e s);
        return s inside {CTEXT_WRITE, KEY_WRITE, INIT_ADDROUNDKEY, INV_SHIFTROWS,
                         INV_SUBBYTES, INV_MIXCOLUMNS, ADDROUNDKEY, PTEXT_READ};
    endfunction

endpackage

// File: rtl/inv_state_manager_if.sv
// Handshake, matrix-control and debug signals of the AES inverse-cipher controller.
// The slave modport is the controller; the master modport is the surrounding datapath/host.
interface inv_state_manager_if;
    logic       start_write_n;
    logic       start_read_n;
    logic       key_expand_done;
    logic       done;
    logic [5:0] dbg_state;
    logic [3:0] dbg_round;
    logic [3:0] matrix_in_sel;
    logic       matrix_write_enable;
    logic       input_mat_row_col;
    logic [1:0] input_mat_idx;
    logic       output_mat_row_col;
    logic [1:0] output_mat_idx;
    logic       key_start;
    logic [3:0] round_key_idx;
    logic [1:0] count_4_out;

    modport master (
        output start_write_n, start_read_n, key_expand_done,
        input  done, dbg_state, dbg_round, matrix_in_sel, matrix_write_enable,
               input_mat_row_col, input_mat_idx, output_mat_row_col, output_mat_idx,
               key_start, round_key_idx, count_4_out
    );

    modport slave (
        input  start_write_n, start_read_n, key_expand_done,
        output done, dbg_state, dbg_round, matrix_in_sel, matrix_write_enable,
               input_mat_row_col, input_mat_idx, output_mat_row_col, output_mat_idx,
               key_start, round_key_idx, count_4_out
    );
endinterface

// File: rtl/inv_state_manager.sv
// Control FSM for the AES-128 inverse cipher: load, key-expansion wait, rounds, readout.
// All outputs decode combinationally from the state, round counter and beat counter.
module inv_state_manager
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    inv_state_manager_if.slave  bus
);

    localparam logic [3:0] FIRST_KEY_IDX   = 4'(NUM_ROUNDS);
    localparam logic [3:0] LAST_ROUND_INIT = 4'(NUM_ROUNDS - 1);

    state_e     state_q, state_d;
    logic [3:0] round_counter_q, round_counter_d;
    logic [1:0] count_4_q, count_4_d;
    logic       beat_last;

    assign beat_last = (count_4_q == 2'd3);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            round_counter_q <= 4'd0;
            count_4_q       <= 2'd0;
        end else begin
            state_q         <= state_d;
            round_counter_q <= round_counter_d;
            count_4_q       <= count_4_d;
        end
    end

    // The beat counter wraps 3->0 on its own, so it is already 0 on entry to the next state
    always_comb begin : next_state
        state_d         = state_q;
        round_counter_d = round_counter_q;
        count_4_d       = is_beat_state(state_q) ? count_4_q + 2'd1 : 2'd0;
        case (state_q)
            IDLE:              if (!bus.start_write_n) state_d = CTEXT_WRITE;
            CTEXT_WRITE:       if (beat_last) state_d = KEY_WRITE;
            KEY_WRITE:         if (beat_last) state_d = COMPUTE_ROUNDKEYS;
            COMPUTE_ROUNDKEYS: begin
                if (bus.key_expand_done) begin
                    state_d         = INIT_ADDROUNDKEY;
                    round_counter_d = LAST_ROUND_INIT;
                end
            end
            INIT_ADDROUNDKEY:  if (beat_last) state_d = INV_SHIFTROWS;
            INV_SHIFTROWS:     if (beat_last) state_d = INV_SUBBYTES;
            INV_SUBBYTES:      if (beat_last) state_d = ADDROUNDKEY;
            ADDROUNDKEY: begin
                if (beat_last) state_d = (round_counter_q == 4'd0) ? DECRYPTION_DONE : INV_MIXCOLUMNS;
            end
            INV_MIXCOLUMNS: begin
                if (beat_last) begin
                    state_d         = INV_SHIFTROWS;
                    round_counter_d = round_counter_q - 4'd1;
                end
            end
            DECRYPTION_DONE:   if (!bus.start_read_n) state_d = PTEXT_READ;
            PTEXT_READ:        if (beat_last) state_d = IDLE;
            default: begin
                state_d         = IDLE;
                round_counter_d = 4'd0;
                count_4_d       = 2'd0;
            end
        endcase
    end

    always_comb begin : decode_outputs
        bus.done                = 1'b0;
        bus.matrix_in_sel       = SEL_EXTERNAL;
        bus.matrix_write_enable = 1'b0;
        bus.input_mat_row_col   = 1'b0;
        bus.input_mat_idx       = 2'd0;
        bus.output_mat_row_col  = 1'b0;
        bus.output_mat_idx      = 2'd0;
        bus.key_start           = 1'b0;
        bus.round_key_idx       = 4'd0;
        case (state_q)
            CTEXT_WRITE: begin
                bus.matrix_write_enable = 1'b1;
                bus.input_mat_row_col   = 1'b1;
                bus.input_mat_idx       = count_4_q;
                bus.key_start           = beat_last;
            end
            KEY_WRITE: bus.input_mat_idx = count_4_q;
            INIT_ADDROUNDKEY, ADDROUNDKEY, INV_SUBBYTES, INV_MIXCOLUMNS, INV_SHIFTROWS: begin
                bus.matrix_write_enable = 1'b1;
                bus.input_mat_row_col   = (state_q != INV_SHIFTROWS);
                bus.input_mat_idx       = count_4_q;
                bus.output_mat_row_col  = (state_q != INV_SHIFTROWS);
                bus.output_mat_idx      = count_4_q;
                case (state_q)
                    INIT_ADDROUNDKEY: begin
                        bus.matrix_in_sel = SEL_ADDROUNDKEY;
                        bus.round_key_idx = FIRST_KEY_IDX;
                    end
                    ADDROUNDKEY: begin
                        bus.matrix_in_sel = SEL_ADDROUNDKEY;
                        bus.round_key_idx = round_counter_q;
                    end
                    INV_SUBBYTES:   bus.matrix_in_sel = SEL_INV_SUBBYTES;
                    INV_MIXCOLUMNS: bus.matrix_in_sel = SEL_INV_MIXCOLUMNS;
                    default:        bus.matrix_in_sel = SEL_INV_SHIFTROWS;
                endcase
            end
            DECRYPTION_DONE: bus.done = 1'b1;
            PTEXT_READ: begin
                bus.output_mat_row_col = 1'b1;
                bus.output_mat_idx     = count_4_q;
            end
            default: ;
        endcase
    end

    assign bus.dbg_state   = {2'b00, state_q};
    assign bus.dbg_round   = round_counter_q;
    assign bus.count_4_out = count_4_q;

endmodule

// File: tb/tb_inv_state_manager.sv
// Randomized self-checking bench for inv_state_manager.
// A timeline model of the decryption schedule predicts every output on every cycle.
module tb_inv_state_manager;
    import aes_ctrl_pkg::*;

    localparam int NR         = NUM_ROUNDS_DEFAULT;
    localparam int DEC_CYCLES = 4 + (NR - 1) * 16 + 12;
    localparam int M_IDLE = 0, M_LOAD = 1, M_WAIT = 2, M_DEC = 3, M_DONE = 4, M_READ = 5;

    typedef struct packed {
        logic       done;
        logic [5:0] st;
        logic [3:0] rnd;
        logic [3:0] sel;
        logic       we;
        logic       irc;
        logic [1:0] iidx;
        logic       orc;
        logic [1:0] oidx;
        logic       ks;
        logic [3:0] rk;
        logic [1:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    inv_state_manager_if bus ();

    inv_state_manager #(.NUM_ROUNDS(NR)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int mode = M_IDLE;
    int t = 0;
    bit modelValid = 1'b0;

    int cycle = 0;
    int ksCount, mcCount, mcAfterLast, initCycle, doneCycle;
    bit sawLastArk;
    logic [5:0] prevState = 6'd0;
    logic prevDone = 1'b0;
    logic [3:0] rkLog[$];

    // The model only knows phases and elapsed time, not the controller's internal states
    always @(posedge clock) begin
        if (reset) begin
            mode       <= M_IDLE;
            t          <= 0;
            modelValid <= 1'b1;
        end else begin
            case (mode)
                M_IDLE: if (!bus.start_write_n) begin mode <= M_LOAD; t <= 0; end
                M_LOAD: if (t == 7) begin mode <= M_WAIT; t <= 0; end else t <= t + 1;
                M_WAIT: if (bus.key_expand_done) begin mode <= M_DEC; t <= 0; end
                M_DEC:  if (t == DEC_CYCLES - 1) begin mode <= M_DONE; t <= 0; end else t <= t + 1;
                M_DONE: if (!bus.start_read_n) begin mode <= M_READ; t <= 0; end
                M_READ: if (t == 3) begin mode <= M_IDLE; t <= 0; end else t <= t + 1;
                default: mode <= M_IDLE;
            endcase
        end
    end

    // Decryption timeline: 4 initial key beats, then 16-cycle rounds of SR/SB/ARK/MC, last round lacks MC
    function automatic exp_t expected(input int m, input int tt);
        exp_t e;
        int u, step, rc;
        e = '0;
        case (m)
            M_LOAD: begin
                e.cnt  = 2'(tt % 4);
                e.iidx = 2'(tt % 4);
                if (tt < 4) begin
                    e.st = 6'd1; e.we = 1'b1; e.irc = 1'b1; e.ks = (tt == 3);
                end else begin
                    e.st = 6'd2;
                end
            end
            M_WAIT: e.st = 6'd3;
            M_DEC: begin
                e.cnt = 2'(tt % 4); e.iidx = e.cnt; e.oidx = e.cnt; e.we = 1'b1;
                if (tt < 4) begin
                    e.st = 6'd10; e.sel = 4'd4; e.irc = 1'b1; e.orc = 1'b1;
                    e.rk = 4'(NR); e.rnd = 4'(NR - 1);
                end else begin
                    u = tt - 4;
                    rc = NR - 1 - u / 16;
                    step = (u % 16) / 4;
                    e.rnd = 4'(rc);
                    e.irc = (step != 0);
                    e.orc = (step != 0);
                    case (step)
                        0: begin e.st = 6'd4; e.sel = 4'd6; end
                        1: begin e.st = 6'd5; e.sel = 4'd5; end
                        2: begin e.st = 6'd7; e.sel = 4'd4; e.rk = 4'(rc); end
                        default: begin e.st = 6'd6; e.sel = 4'd7; end
                    endcase
                end
            end
            M_DONE: begin e.st = 6'd8; e.done = 1'b1; end
            M_READ: begin
                e.st = 6'd9; e.orc = 1'b1; e.oidx = 2'(tt); e.cnt = 2'(tt);
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, actual, required);
        end
    endtask

    task automatic logRun();
        if (bus.key_start === 1'b1) ksCount++;
        if (bus.matrix_in_sel === 4'd7) begin
            mcCount++;
            if (sawLastArk) mcAfterLast++;
        end
        if (bus.dbg_state === 6'd7 && bus.dbg_round === 4'd0) sawLastArk = 1'b1;
        if (bus.matrix_in_sel === 4'd4 && bus.matrix_write_enable === 1'b1) rkLog.push_back(bus.round_key_idx);
        if (bus.dbg_state === 6'd10 && prevState !== 6'd10) initCycle = cycle;
        if (bus.done === 1'b1 && prevDone !== 1'b1) doneCycle = cycle;
        prevState = bus.dbg_state;
        prevDone  = bus.done;
    endtask

    task automatic stepCycles(input int n);
        exp_t e;
        repeat (n) begin
            @(negedge clock);
            cycle++;
            if (modelValid) begin
                e = expected(mode, t);
                checkOutput("dbg_state",     16'(bus.dbg_state),           16'(e.st));
                checkOutput("dbg_round",     16'(bus.dbg_round),           16'(e.rnd));
                checkOutput("count_4_out",   16'(bus.count_4_out),         16'(e.cnt));
                checkOutput("done",          16'(bus.done),                16'(e.done));
                checkOutput("matrix_in_sel", 16'(bus.matrix_in_sel),       16'(e.sel));
                checkOutput("write_enable",  16'(bus.matrix_write_enable), 16'(e.we));
                checkOutput("in_row_col",    16'(bus.input_mat_row_col),   16'(e.irc));
                checkOutput("in_idx",        16'(bus.input_mat_idx),       16'(e.iidx));
                checkOutput("out_row_col",   16'(bus.output_mat_row_col),  16'(e.orc));
                checkOutput("out_idx",       16'(bus.output_mat_idx),      16'(e.oidx));
                checkOutput("key_start",     16'(bus.key_start),           16'(e.ks));
                checkOutput("round_key_idx", 16'(bus.round_key_idx),       16'(e.rk));
            end
            logRun();
        end
    endtask

    task automatic randomizeInputs();
        bus.start_write_n   = 1'($urandom_range(0, 1));
        bus.start_read_n    = 1'($urandom_range(0, 1));
        bus.key_expand_done = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input int kedDelay, input bit bothLow);
        ksCount = 0; mcCount = 0; mcAfterLast = 0; sawLastArk = 1'b0;
        initCycle = -1; doneCycle = -1000;
        rkLog.delete();
        bus.start_write_n   = 1'b0;
        bus.start_read_n    = bothLow ? 1'b0 : 1'b1;
        bus.key_expand_done = 1'($urandom_range(0, 1));
        stepCycles(1);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                checkOutput("ctext_state", 16'(bus.dbg_state),           16'd1);
                checkOutput("ctext_sel",   16'(bus.matrix_in_sel),       16'd0);
                checkOutput("ctext_we",    16'(bus.matrix_write_enable), 16'd1);
                checkOutput("ctext_idx",   16'(bus.input_mat_idx),       16'(i));
            end
            randomizeInputs();
            stepCycles(1);
        end
        bus.key_expand_done = 1'b0;
        for (int i = 0; i < kedDelay; i++) begin
            bus.start_write_n = 1'($urandom_range(0, 1));
            bus.start_read_n  = 1'($urandom_range(0, 1));
            stepCycles(1);
        end
        checkOutput("stall_state", 16'(bus.dbg_state),           16'd3);
        checkOutput("stall_we",    16'(bus.matrix_write_enable), 16'd0);
        bus.key_expand_done = 1'b1;
        stepCycles(1);
        for (int i = 0; i < DEC_CYCLES; i++) begin
            randomizeInputs();
            if (i % 3 == 0) bus.start_read_n = 1'b0;
            stepCycles(1);
        end
        checkOutput("done_level", 16'(bus.done), 16'd1);
        repeat ($urandom_range(1, 4)) begin
            randomizeInputs();
            bus.start_read_n = 1'b1;
            stepCycles(1);
        end
        bus.start_read_n = 1'b0;
        stepCycles(1);
        for (int i = 0; i < 4; i++) begin
            checkOutput("ptext_state", 16'(bus.dbg_state),          16'd9);
            checkOutput("ptext_col",   16'(bus.output_mat_row_col), 16'd1);
            checkOutput("ptext_idx",   16'(bus.output_mat_idx),     16'(i));
            randomizeInputs();
            stepCycles(1);
        end
        bus.start_write_n = 1'b1;
        checkOutput("idle_state", 16'(bus.dbg_state), 16'd0);
        checkOutput("idle_done",  16'(bus.done),      16'd0);
        stepCycles(2);

        checkOutput("key_start_pulses", 16'(ksCount),             16'd1);
        checkOutput("invmix_cycles",    16'(mcCount),             16'd36);
        checkOutput("invmix_after_last", 16'(mcAfterLast),        16'd0);
        checkOutput("done_latency",     16'(doneCycle - initCycle), 16'd160);
        checkOutput("rk_beats",         16'(rkLog.size()),        16'd44);
        for (int i = 0; i < rkLog.size() && i < 44; i++)
            checkOutput("rk_order", 16'(rkLog[i]), 16'(10 - i / 4));
    endtask

    initial begin
        bus.start_write_n   = 1'b1;
        bus.start_read_n    = 1'b1;
        bus.key_expand_done = 1'b0;
        stepCycles(2);
        reset = 1'b0;
        checkOutput("reset_state", 16'(bus.dbg_state), 16'd0);
        checkOutput("reset_round", 16'(bus.dbg_round), 16'd0);
        stepCycles(3);

        $display("[TB] run 1: both starts low, key ready after 5 cycles");
        applyStimulus(5, 1'b1);
        $display("[TB] run 2: random key-expansion delay");
        applyStimulus($urandom_range(0, 20), 1'b0);

        $display("[TB] reset abort during InvSubBytes");
        bus.start_write_n = 1'b0;
        bus.start_read_n  = 1'b1;
        stepCycles(1);
        bus.start_write_n = 1'b1;
        stepCycles(8);
        stepCycles(2);
        bus.key_expand_done = 1'b1;
        stepCycles(1);
        bus.key_expand_done = 1'b0;
        stepCycles(8);
        checkOutput("pre_abort_state", 16'(bus.dbg_state), 16'd5);
        reset = 1'b1;
        stepCycles(2);
        reset = 1'b0;
        checkOutput("abort_state", 16'(bus.dbg_state),           16'd0);
        checkOutput("abort_round", 16'(bus.dbg_round),           16'd0);
        checkOutput("abort_count", 16'(bus.count_4_out),         16'd0);
        checkOutput("abort_we",    16'(bus.matrix_write_enable), 16'd0);
        checkOutput("abort_sel",   16'(bus.matrix_in_sel),       16'd0);
        checkOutput("abort_rk",    16'(bus.round_key_idx),       16'd0);
        stepCycles(3);

        $display("[TB] run 3: key expansion stalled 1000 cycles");
        applyStimulus(1000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
